// File: rtl/rv32ima_pkg.sv
// Shared encodings for the memory arbiter: load/store width codes and arbiter FSM states.
package rv32ima_pkg;
  localparam int LDST_WIDTH_W = 2;
  localparam logic [LDST_WIDTH_W-1:0] LDST_BYTE = 2'd0;
  localparam logic [LDST_WIDTH_W-1:0] LDST_HALF = 2'd1;
  localparam logic [LDST_WIDTH_W-1:0] LDST_WORD = 2'd2;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} arb_state_t;
endpackage

// File: rtl/datapath_if.sv
// Datapath <-> memory arbiter bundle; the arbiter uses the mem modport.
interface datapath_if;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic        dmem_wen;
  logic        dmem_ren;
  logic [31:0] dmem_store;
  logic [31:0] dmem_addr;
  logic [rv32ima_pkg::LDST_WIDTH_W-1:0] dmem_width;
  logic [31:0] imem_load;
  logic        ihit;
  logic        dhit;
  logic [31:0] dmem_load;

  modport mem (
    input  imem_addr, imem_ren, dmem_wen, dmem_ren, dmem_store, dmem_addr, dmem_width,
    output imem_load, ihit, dhit, dmem_load
  );
  modport dp (
    output imem_addr, imem_ren, dmem_wen, dmem_ren, dmem_store, dmem_addr, dmem_width,
    input  imem_load, ihit, dhit, dmem_load
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write strobes, store replication, load extraction and misalign detect.
module mem_lane_align
  import rv32ima_pkg::*;
(
  input  logic [1:0]              byte_off,
  input  logic [LDST_WIDTH_W-1:0] width,
  input  logic [31:0]             store,
  input  logic [31:0]             raw_load,
  output logic [3:0]              wstrb,
  output logic [31:0]             wdata,
  output logic [31:0]             load,
  output logic                    misalign
);
  logic [3:0][7:0]  lanes;
  logic [1:0][15:0] halves;

  assign lanes  = raw_load;
  assign halves = raw_load;

  // Loads are zero-extended; sign extension belongs to the datapath.
  always_comb begin
    wstrb    = 4'b1111;
    wdata    = store;
    load     = raw_load;
    misalign = |byte_off;
    case (width)
      LDST_BYTE: begin
        wstrb    = 4'b0001 << byte_off;
        wdata    = {4{store[7:0]}};
        load     = {24'h0, lanes[byte_off]};
        misalign = 1'b0;
      end
      LDST_HALF: begin
        wstrb    = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store[15:0]}};
        load     = {16'h0, halves[byte_off[1]]};
        misalign = byte_off[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first.
// Optional wait-cycle abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import rv32ima_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  datapath_if.mem     dp,
  output logic        ram_req,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wstrb,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        dmem_misalign
);
  arb_state_t state_q, state_d;
  logic [31:0] addr_q, store_q, imem_load_q, dmem_load_q, lane_load;
  logic [LDST_WIDTH_W-1:0] width_q;
  logic wen_q, is_d_q, take_d, take_i, mis, timeout;

  mem_lane_align u_align (
    .byte_off (addr_q[1:0]),
    .width    (width_q),
    .store    (store_q),
    .raw_load (ram_load),
    .wstrb    (ram_wstrb),
    .wdata    (ram_store),
    .load     (lane_load),
    .misalign (mis)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_q;

  always_ff @(posedge clk or negedge nrst)
    if (!nrst)                     wait_q <= '0;
    else if (ram_req && !ram_ready) wait_q <= wait_q + 1'b1;
    else                           wait_q <= '0;

  assign timeout = ram_req && !ram_ready && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No abort path: the RAM is trusted to answer eventually.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    take_d  = 1'b0;
    take_i  = 1'b0;
    case (state_q)
      IDLE:
        if (dp.dmem_ren || dp.dmem_wen) begin
          state_d = DACC;
          take_d  = 1'b1;
        end else if (dp.imem_ren) begin
          state_d = IACC;
          take_i  = 1'b1;
        end
      IACC: if (ram_ready || timeout) state_d = RESP;
      DACC: if (mis || ram_ready || timeout) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      store_q     <= '0;
      width_q     <= '0;
      wen_q       <= 1'b0;
      is_d_q      <= 1'b0;
      imem_load_q <= '0;
      dmem_load_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_d) begin
        addr_q  <= dp.dmem_addr;
        store_q <= dp.dmem_store;
        width_q <= dp.dmem_width;
        wen_q   <= dp.dmem_wen;
        is_d_q  <= 1'b1;
      end else if (take_i) begin
        addr_q  <= dp.imem_addr;
        store_q <= '0;
        width_q <= LDST_WORD;
        wen_q   <= 1'b0;
        is_d_q  <= 1'b0;
      end
      if (state_q == IACC) begin
        if (ram_ready)    imem_load_q <= ram_load;
        else if (timeout) imem_load_q <= TIMEOUT_DATA;
      end
      if (state_q == DACC) begin
        if (mis)            dmem_load_q <= '0;
        else if (ram_ready) dmem_load_q <= lane_load;
        else if (timeout)   dmem_load_q <= TIMEOUT_DATA;
      end
    end
  end

  // Misaligned data accesses never reach the RAM.
  assign ram_req       = (state_q == IACC) || (state_q == DACC && !mis);
  assign ram_wen       = wen_q;
  assign ram_addr      = {addr_q[31:2], 2'b00};
  assign dp.ihit       = (state_q == RESP) && !is_d_q;
  assign dp.dhit       = (state_q == RESP) && is_d_q;
  assign dmem_misalign = (state_q == RESP) && is_d_q && mis;
  assign dp.imem_load  = imem_load_q;
  assign dp.dmem_load  = dmem_load_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-addressed reference memory, randomized RAM wait states.
module tb_mem_arbiter;
  import rv32ima_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        ram_req, ram_wen, ram_ready, dmem_misalign;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic [3:0]  ram_wstrb;

  datapath_if dpif();

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .dp            (dpif),
    .ram_req       (ram_req),
    .ram_wen       (ram_wen),
    .ram_addr      (ram_addr),
    .ram_wstrb     (ram_wstrb),
    .ram_store     (ram_store),
    .ram_load      (ram_load),
    .ram_ready     (ram_ready),
    .dmem_misalign (dmem_misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          chk_load;
    logic [31:0] load;
    bit          mis;
    int          cyc;
  } hit_t;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    bit          chk_w;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          waits;
    bit          hang;
    bit          abort;
  } ram_t;

  hit_t sb[$];
  ram_t rq[$];

  logic [31:0] ram_mem [256];
  logic [7:0]  ref_b [1024];

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] wd);
    int i;
    i = int'(a[9:0]);
    if (wd == LDST_BYTE)      return {24'h0, ref_b[i]};
    else if (wd == LDST_HALF) return {16'h0, ref_b[i+1], ref_b[i]};
    else                      return {ref_b[i+3], ref_b[i+2], ref_b[i+1], ref_b[i]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    ram_mem[a[9:2]] = v;
    for (int j = 0; j < 4; j++) ref_b[int'({a[9:2], 2'b00}) + j] = v[j*8 +: 8];
  endtask

  // ---------------- RAM responder ----------------
  ram_t re;
  bit   aborted;
  int   rn;
  initial begin
    ram_ready = 1'b0;
    ram_load  = '0;
    forever begin
      @(negedge clk);
      if (nrst && ram_req) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ram_req: addr %h wen %0b, no access expected", ram_addr, ram_wen);
          ram_load = '0; ram_ready = 1'b1;
          @(negedge clk); ram_ready = 1'b0;
        end else begin
          re = rq.pop_front();
          chk("ram_wen", ram_wen, re.wen);
          chk("ram_addr", ram_addr, re.addr);
          if (re.chk_w) begin
            chk("ram_wstrb", ram_wstrb, re.wstrb);
            chk("ram_store", ram_store, re.wdata);
          end
          if (re.hang) begin
            rn = 0;
            while (ram_req && rn < 40) begin @(negedge clk); rn++; end
            chk("timeout_req_cycles", rn, TO);
          end else begin
            aborted = 1'b0;
            for (int i = 0; i < re.waits; i++) begin
              @(negedge clk);
              if (!nrst) begin aborted = 1'b1; break; end
            end
            chk("access_aborted", aborted, re.abort);
            if (aborted) begin
              rn = 0;
              while (!nrst && rn < 50) begin @(negedge clk); rn++; end
              @(negedge clk);
              ram_load = $urandom; ram_ready = 1'b1;   // stray completion while idle
              @(negedge clk); ram_ready = 1'b0;
            end else begin
              chk("ram_req_held", ram_req, 1'b1);
              chk("ram_addr_stable", ram_addr, re.addr);
              if (re.wen) begin
                for (int j = 0; j < 4; j++)
                  if (ram_wstrb[j]) ram_mem[ram_addr[9:2]][j*8 +: 8] = ram_store[j*8 +: 8];
                ram_load = $urandom;
              end else begin
                ram_load = ram_mem[ram_addr[9:2]];
              end
              ram_ready = 1'b1;
              @(negedge clk); ram_ready = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- hit monitor ----------------
  hit_t he;
  initial begin
    forever begin
      @(negedge clk);
      if (dpif.ihit || dpif.dhit) begin
        chk("hit_overlap", {31'h0, dpif.ihit & dpif.dhit}, 32'h0);
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_hit: ihit %0b dhit %0b, no hit expected", dpif.ihit, dpif.dhit);
        end else begin
          he = sb.pop_front();
          chk("hit_is_dhit", dpif.dhit, he.is_d);
          chk("hit_cycle", cyc, he.cyc);
          if (he.is_d) begin
            chk("dmem_misalign", dmem_misalign, he.mis);
            if (he.chk_load) chk("dmem_load", dpif.dmem_load, he.load);
          end else begin
            chk("imem_load", dpif.imem_load, he.load);
          end
        end
      end else if (dmem_misalign) begin
        n_checks++; n_fail++;
        $display("FAIL misalign_without_dhit: dmem_misalign 1, dhit 0");
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_fetch(input logic [31:0] a, input int w);
    rq.push_back('{wen: 1'b0, addr: {a[31:2], 2'b00}, chk_w: 1'b0, wstrb: 4'h0, wdata: 32'h0,
                   waits: w, hang: 1'b0, abort: 1'b0});
    sb.push_back('{is_d: 1'b0, chk_load: 1'b1, load: ref_load(a, LDST_WORD), mis: 1'b0, cyc: cyc + 2 + w});
    dpif.imem_addr = a;
    dpif.imem_ren  = 1'b1;
    @(negedge clk);
    dpif.imem_ren  = 1'b0;
  endtask

  task automatic issue_data(input bit wr, input bit both, input logic [31:0] a,
                            input logic [1:0] wd, input logic [31:0] d, input int w);
    bit          mis;
    logic [3:0]  strb;
    logic [31:0] wdat;
    mis = (wd == LDST_HALF && a[0]) || (wd == LDST_WORD && a[1:0] != 2'b00);
    if (mis) begin
      sb.push_back('{is_d: 1'b1, chk_load: 1'b1, load: 32'h0, mis: 1'b1, cyc: cyc + 2});
    end else begin
      if (wd == LDST_BYTE)      begin strb = 4'b0001 << a[1:0];          wdat = {4{d[7:0]}}; end
      else if (wd == LDST_HALF) begin strb = a[1] ? 4'b1100 : 4'b0011;   wdat = {2{d[15:0]}}; end
      else                      begin strb = 4'b1111;                    wdat = d; end
      rq.push_back('{wen: wr, addr: {a[31:2], 2'b00}, chk_w: wr, wstrb: strb, wdata: wdat,
                     waits: w, hang: 1'b0, abort: 1'b0});
      sb.push_back('{is_d: 1'b1, chk_load: !wr, load: ref_load(a, wd), mis: 1'b0, cyc: cyc + 2 + w});
      if (wr) begin
        ref_b[int'(a[9:0])] = d[7:0];
        if (wd != LDST_BYTE) ref_b[int'(a[9:0]) + 1] = d[15:8];
        if (wd == LDST_WORD) begin
          ref_b[int'(a[9:0]) + 2] = d[23:16];
          ref_b[int'(a[9:0]) + 3] = d[31:24];
        end
      end
    end
    dpif.dmem_addr  = a;
    dpif.dmem_width = wd;
    dpif.dmem_store = d;
    dpif.dmem_wen   = wr;
    dpif.dmem_ren   = !wr || both;
    @(negedge clk);
    dpif.dmem_wen   = 1'b0;
    dpif.dmem_ren   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || rq.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: %0d hits and %0d accesses still pending", sb.size(), rq.size());
      sb.delete(); rq.delete();
    end
    @(negedge clk);
  endtask

  int          r_kind, r_w, c0;
  logic [31:0] r_a, r_d;
  logic [1:0]  r_wd;

  initial begin
    dpif.imem_addr = '0; dpif.imem_ren = 1'b0;
    dpif.dmem_addr = '0; dpif.dmem_ren = 1'b0; dpif.dmem_wen = 1'b0;
    dpif.dmem_store = '0; dpif.dmem_width = LDST_WORD;
    for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
    set_word(32'h100, 32'h0000_0013);
    set_word(32'h300, 32'h8001_1234);

    repeat (2) @(negedge clk);
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_ihit", dpif.ihit, 1'b0);
    chk("rst_dhit", dpif.dhit, 1'b0);
    chk("rst_misalign", dmem_misalign, 1'b0);
    chk("rst_imem_load", dpif.imem_load, 32'h0);
    chk("rst_dmem_load", dpif.dmem_load, 32'h0);
    nrst = 1'b1;
    @(negedge clk);

    issue_fetch(32'h100, 0); wait_done();
    chk("fetch_0x100", dpif.imem_load, 32'h0000_0013);

    issue_data(1'b1, 1'b0, 32'h203, LDST_BYTE, 32'h0000_00AB, 1); wait_done();
    issue_data(1'b0, 1'b0, 32'h302, LDST_HALF, 32'h0, 0); wait_done();
    chk("half_load_0x302", dpif.dmem_load, 32'h0000_8001);
    issue_data(1'b0, 1'b0, 32'h301, LDST_HALF, 32'h0, 0); wait_done();
    chk("misaligned_load_zero", dpif.dmem_load, 32'h0);

    // Data and fetch in the same cycle: data first, fetch after RESP->IDLE.
    c0 = cyc;
    rq.push_back('{wen: 1'b0, addr: 32'h040, chk_w: 1'b0, wstrb: 4'h0, wdata: 32'h0, waits: 0, hang: 1'b0, abort: 1'b0});
    rq.push_back('{wen: 1'b0, addr: 32'h080, chk_w: 1'b0, wstrb: 4'h0, wdata: 32'h0, waits: 0, hang: 1'b0, abort: 1'b0});
    sb.push_back('{is_d: 1'b1, chk_load: 1'b1, load: ref_load(32'h040, LDST_WORD), mis: 1'b0, cyc: c0 + 2});
    sb.push_back('{is_d: 1'b0, chk_load: 1'b1, load: ref_load(32'h080, LDST_WORD), mis: 1'b0, cyc: c0 + 5});
    dpif.dmem_addr = 32'h040; dpif.dmem_width = LDST_WORD; dpif.dmem_ren = 1'b1;
    dpif.imem_addr = 32'h080; dpif.imem_ren = 1'b1;
    @(negedge clk); dpif.dmem_ren = 1'b0;
    repeat (3) @(negedge clk); dpif.imem_ren = 1'b0;
    wait_done();

    for (int k = 0; k < 150; k++) begin
      r_kind = int'($urandom_range(0, 2));
      r_w    = int'($urandom_range(0, 3));
      r_a    = 32'($urandom_range(0, 1019));
      r_wd   = 2'($urandom_range(0, 2));
      r_d    = $urandom;
      if (r_kind == 0)      issue_fetch({r_a[31:2], 2'b00}, r_w);
      else if (r_kind == 1) issue_data(1'b0, 1'b0, r_a, r_wd, r_d, r_w);
      else                  issue_data(1'b1, r_d[31], r_a, r_wd, r_d, r_w);
      wait_done();
    end

    // Reset in the middle of a 3-wait data read.
    rq.push_back('{wen: 1'b0, addr: 32'h0C0, chk_w: 1'b0, wstrb: 4'h0, wdata: 32'h0, waits: 3, hang: 1'b0, abort: 1'b1});
    dpif.dmem_addr = 32'h0C0; dpif.dmem_width = LDST_WORD; dpif.dmem_ren = 1'b1;
    @(negedge clk); dpif.dmem_ren = 1'b0;
    chk("ram_req_before_reset", ram_req, 1'b1);
    #2 nrst = 1'b0;
    #1 chk("ram_req_async_drop", ram_req, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_mid_imem_load", dpif.imem_load, 32'h0);
    chk("rst_mid_dmem_load", dpif.dmem_load, 32'h0);
    chk("rst_mid_ram_addr", ram_addr, 32'h0);
    nrst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_ram_req", ram_req, 1'b0);
    chk("post_reset_dhit", dpif.dhit, 1'b0);
    chk("post_reset_pending", rq.size(), 0);

`ifdef MEM_ARB_TIMEOUT_EN
    rq.push_back('{wen: 1'b0, addr: 32'h080, chk_w: 1'b0, wstrb: 4'h0, wdata: 32'h0, waits: 0, hang: 1'b1, abort: 1'b0});
    sb.push_back('{is_d: 1'b0, chk_load: 1'b1, load: 32'hDEAD_BEEF, mis: 1'b0, cyc: cyc + 1 + TO});
    dpif.imem_addr = 32'h080; dpif.imem_ren = 1'b1;
    @(negedge clk); dpif.imem_ren = 1'b0;
    wait_done();
    chk("timeout_load", dpif.imem_load, 32'hDEAD_BEEF);
`endif

    issue_fetch(32'h100, 2); wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, RAM wait-cycle limit before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 Datapath side SHALL be the mem modport of datapath_if: inputs imem_addr, imem_ren, dmem_wen, dmem_ren, dmem_store, dmem_addr, dmem_width; outputs imem_load, ihit, dhit, dmem_load.
REQ-005 ram_req  output  1  RAM access request, held until ram_ready.
REQ-006 ram_wen  output  1  1 = write, 0 = read; valid while ram_req.
REQ-007 ram_addr  output  32  word-aligned address (bits[1:0] = 0).
REQ-008 ram_wstrb  output  4  byte-lane write strobes.
REQ-009 ram_store  output  32  write data, lane-replicated.
REQ-010 ram_load  input  32  read data, valid when ram_ready.
REQ-011 ram_ready  input  1  one-cycle completion pulse from RAM.
REQ-012 dmem_misalign  output  1  pulses with dhit on a misaligned data access.

Function
REQ-013 FSM states SHALL be IDLE, IACC, DACC, RESP.
- IDLE: dmem_ren|dmem_wen -> DACC; else imem_ren -> IACC; else stay.
- Data has priority over instruction when both request in the same cycle.
- On leaving IDLE: latch address, store data, width, and direction.
REQ-014 In IACC/DACC, ram_req SHALL be 1 with latched values stable; on ram_ready, latch ram_load and go to RESP.
REQ-015 RESP SHALL pulse exactly one of ihit/dhit for one cycle with imem_load/dmem_load valid, then return to IDLE; the request is not resampled in RESP.
REQ-016 Latency: request at edge t, zero-wait RAM (ram_ready first ACCESS cycle) -> hit asserted in cycle t+2; each RAM wait cycle adds one.
REQ-017 ihit and dhit SHALL never be asserted in the same cycle.
REQ-018 dmem_wen and dmem_ren both high SHALL be treated as a write.
REQ-019 Loads SHALL return the selected byte/half right-aligned and zero-extended (sign extension is the datapath's job); word loads unmodified.
REQ-020 Stores: byte data replicated to all 4 lanes with ram_wstrb = 1<<addr[1:0]; half replicated to both halves with strobes 0011/1100 by addr[1]; word uses 1111.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no RAM access; DACC -> RESP directly, dhit and dmem_misalign pulse, dmem_load = 0.
REQ-022 Outputs SHALL hold their last values in IDLE except ihit, dhit, dmem_misalign, and ram_req, which are 0.

Reset
REQ-023 nrst low SHALL immediately force IDLE; ram_req, ihit, dhit, dmem_misalign = 0; imem_load, dmem_load, and latched registers = 0.
REQ-024 Reset mid-access SHALL drop ram_req asynchronously; a later stray ram_ready in IDLE SHALL be ignored.

Configuration
REQ-025 Macro MEM_ARB_TIMEOUT_EN:
- Defined: a wait counter runs in IACC/DACC. After TIMEOUT_CYCLES cycles without ram_ready, the access is aborted: ram_req drops, RESP is entered, and the hit pulses with load data 32'hDEAD_BEEF.
- Undefined: no counter; the arbiter waits indefinitely.

Structure
REQ-026 rv32ima_pkg SHALL hold the width encoding (LDST_WIDTH_W, LDST_BYTE/LDST_HALF/LDST_WORD) and the arbiter state enum.
REQ-027 Lane steering (strobe, store replication, load extraction, misalign detect) SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-028 Instruction fetch:
- Stimulus: imem_ren, imem_addr=0x100, zero-wait RAM returning 0x00000013.
- Response: ihit exactly 2 cycles later; imem_load=0x00000013.
REQ-029 Simultaneous requests:
- Stimulus: imem_ren and dmem_ren together.
- Response: DACC served first with dhit; IACC follows; ihit and dhit never overlap.
REQ-030 Byte store:
- Stimulus: dmem_addr=0x203, width=byte, dmem_store=0x000000AB.
- Response: ram_addr=0x200, ram_wstrb=1000, ram_store=0xABABABAB.
REQ-031 Half load:
- Stimulus: dmem_addr=0x302, ram_load=0x8001_1234.
- Response: dmem_load=0x0000_8001.
- Same load at 0x301: dmem_misalign=1, ram_req never asserted.
REQ-032 Reset mid-access:
- Stimulus: nrst low during DACC with 3 RAM wait states.
- Response: ram_req falls the same cycle; no hit after release.
REQ-033 Timeout (MEM_ARB_TIMEOUT_EN defined):
- Stimulus: TIMEOUT_CYCLES=4, RAM never ready.
- Response: ihit after 4 wait cycles; imem_load=0xDEADBEEF.
